// File: rtl/imem_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SIZE   = 256;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WR    = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6
  } state_t;

  // States in which the byte stream may be consumed.
  function automatic logic takes_byte(input state_t s);
    return (s == COUNT) || (s == HI) || (s == LO) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program image loader: frames [N][hi lo]*(N+1)[CHK] into 16-bit
// instruction memory writes, holding the CPU in reset while loading.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   xor_q, xor_d;

  logic                in_ready_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                cpu_hold_d;
  logic                busy_d;
  logic                done_d;
  logic                err_d;

  logic                accept_c;

  // in_ready is registered from the state it describes, so it is exact here.
  assign accept_c = in_valid & in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_hold_d  = cpu_hold;
    done_d      = 1'b0;
    err_d       = err;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COUNT;
          err_d      = 1'b0;
          addr_d     = '0;
          xor_d      = '0;
          mem_addr_d = '0;
          cpu_hold_d = 1'b1;
        end
      end
      COUNT: begin
        if (accept_c) begin
          rem_d   = ADDR_W'(in_byte);
          state_d = HI;
        end
      end
      HI: begin
        if (accept_c) begin
          hi_d    = in_byte;
          xor_d   = xor_q ^ in_byte;
          state_d = LO;
        end
      end
      LO: begin
        if (accept_c) begin
          xor_d       = xor_q ^ in_byte;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = {hi_q, in_byte};
          state_d     = WR;
        end
      end
      WR: begin
        // Remaining counts down, so the address never wraps inside a frame.
        if (rem_q != '0) begin
          rem_d   = rem_q - ADDR_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = HI;
        end else begin
          state_d = CHK;
        end
      end
      CHK: begin
        if (accept_c) begin
          err_d      = (in_byte != xor_q);
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = takes_byte(state_d);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; CPU stays held out of reset until a load completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      xor_q     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      xor_q     <= xor_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_hold  <= cpu_hold_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
